// File: rtl/uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_tx_pkg;

  // Register word offsets (alu_out[3:2])
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // STATUS register bit positions
  localparam int unsigned ST_SHIFTING  = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_EMPTY     = 2;
  localparam int unsigned ST_OVERFLOW  = 3;
  localparam int unsigned ST_COUNT_LSB = 4;
  localparam int unsigned ST_COUNT_W   = 5;

  // Serial framing FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; a pop frees the slot first, so push+pop while full is accepted.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer, occupancy and storage update
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// UART transmitter bus slave: register file, FIFO, framing FSM and read mux.
module uart_tx_periph
  import uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  A,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_lat_q, div_lat_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic [15:0] div_q, div_d;
  logic        en_q, en_d;
  logic        ovf_q, ovf_d;

  logic          push_req_c;
  logic          fifo_pop_c;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [15:0]   div_eff_c;
  logic          start_ok_c;
  logic [31:0]   status_c;
  logic          wd_unused_c;

  assign push_req_c  = WE && (A == ADDR_DATA);
  assign div_eff_c   = (div_q == 16'd0) ? 16'd1 : div_q;
  assign start_ok_c  = en_q & ~fifo_empty;
  assign tx          = tx_q;
  assign busy        = (state_q != IDLE) | ~fifo_empty;
  assign wd_unused_c = ^WD[31:16];

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req_c),
    .pop   (fifo_pop_c),
    .din   (WD[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State, datapath and register storage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_lat_q <= 16'd1;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      div_q     <= 16'(DEFAULT_DIV);
      en_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_lat_q <= div_lat_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      div_q     <= div_d;
      en_q      <= en_d;
      ovf_q     <= ovf_d;
    end
  end

  // Framing FSM: a frame start pops the head byte and latches the divisor
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_lat_d  = div_lat_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok_c) begin
          state_d    = START;
          fifo_pop_c = 1'b1;
          shift_d    = fifo_dout;
          tx_d       = 1'b0;
          div_lat_d  = div_eff_c;
          cnt_d      = div_eff_c - 16'd1;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
          cnt_d     = div_lat_q - 16'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = div_lat_q - 16'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == 16'd0) begin
          if (start_ok_c) begin
            state_d    = START;
            fifo_pop_c = 1'b1;
            shift_d    = fifo_dout;
            tx_d       = 1'b0;
            div_lat_d  = div_eff_c;
            cnt_d      = div_eff_c - 16'd1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register writes and sticky overflow (dropped push while full without a pop)
  always_comb begin
    div_d = div_q;
    en_d  = en_q;
    ovf_d = ovf_q;
    if (WE) begin
      case (A)
        ADDR_STATUS: ovf_d = 1'b0;
        ADDR_DIV:    div_d = WD[15:0];
        ADDR_CTRL:   en_d  = WD[0];
        default:     ;
      endcase
    end
    if (push_req_c && fifo_full && !fifo_pop_c) begin
      ovf_d = 1'b1;
    end
  end

  // Side-effect-free read mux
  always_comb begin
    status_c = '0;
    status_c[ST_SHIFTING] = (state_q != IDLE);
    status_c[ST_FULL]     = fifo_full;
    status_c[ST_EMPTY]    = fifo_empty;
    status_c[ST_OVERFLOW] = ovf_q;
    status_c[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
    case (A)
      ADDR_STATUS: RD = status_c;
      ADDR_DIV:    RD = {16'd0, div_q};
      ADDR_CTRL:   RD = {31'd0, en_q};
      default:     RD = '0;
    endcase
  end

endmodule
